// File: rtl/alu_pipe.sv
// Two-stage pipelined data-processing ALU: E1 operand register, E2 compute + result/flag register.
// Optional macro ALU_CARRY_FWD_EN: ADC/SBC/RSC take carry from the pipeline's own NZCV state.
module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode_in,
    input  logic             s_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             shift_c_in,
    input  logic             carry_in,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             rd_we,
    output logic             flags_we,
    output logic [TAG_W-1:0] tag_out,
    output logic [3:0]       flags_out
);

    typedef enum logic [3:0] {
        OP_AND = 4'd0,  OP_EOR = 4'd1,  OP_SUB = 4'd2,  OP_RSB = 4'd3,
        OP_ADD = 4'd4,  OP_ADC = 4'd5,  OP_SBC = 4'd6,  OP_RSC = 4'd7,
        OP_TST = 4'd8,  OP_TEQ = 4'd9,  OP_CMP = 4'd10, OP_CMN = 4'd11,
        OP_ORR = 4'd12, OP_MOV = 4'd13, OP_BIC = 4'd14, OP_MVN = 4'd15
    } op_e;

    // E1 operand stage
    logic             e1_valid_q;
    op_e              e1_op_q;
    logic             e1_s_q;
    logic [WIDTH-1:0] e1_a_q;
    logic [WIDTH-1:0] e1_b_q;
    logic             e1_shc_q;
    logic [TAG_W-1:0] e1_tag_q;
`ifndef ALU_CARRY_FWD_EN
    logic             e1_cin_q;
`endif

    // E2 result stage
    logic             e2_valid_q;
    logic [WIDTH-1:0] alu_q;
    logic             rd_we_q;
    logic             flags_we_q;
    logic [TAG_W-1:0] tag_q;
    logic [3:0]       flags_q;

    logic             e1_adv;
    logic             e2_adv;

    logic [WIDTH-1:0] alu_d;
    logic [3:0]       flags_d;
    logic             set_flags_d;
    logic             is_test_d;
    logic             carry_sel;

    logic [WIDTH-1:0] add_x;
    logic [WIDTH-1:0] add_y;
    logic             add_cin;
    logic             arith;
    logic [WIDTH:0]   sum;
    logic             c_res;
    logic             v_res;

    assign e2_adv   = !e2_valid_q || out_ready;
    assign e1_adv   = !e1_valid_q || e2_adv;
    assign in_ready = e1_adv;

`ifdef ALU_CARRY_FWD_EN
    // An older flag-setter writes flags_q on the very edge it leaves E1, so by the
    // time a dependent op sits in E1 the register already holds the bypassed C.
    assign carry_sel = flags_q[1];
`else
    assign carry_sel = e1_cin_q;
`endif

    always_comb begin
        add_x   = e1_a_q;
        add_y   = e1_b_q;
        add_cin = 1'b0;
        arith   = 1'b1;
        alu_d   = '0;
        case (e1_op_q)
            OP_AND, OP_TST: begin alu_d = e1_a_q & e1_b_q;  arith = 1'b0; end
            OP_EOR, OP_TEQ: begin alu_d = e1_a_q ^ e1_b_q;  arith = 1'b0; end
            OP_ORR:         begin alu_d = e1_a_q | e1_b_q;  arith = 1'b0; end
            OP_MOV:         begin alu_d = e1_b_q;           arith = 1'b0; end
            OP_BIC:         begin alu_d = e1_a_q & ~e1_b_q; arith = 1'b0; end
            OP_MVN:         begin alu_d = ~e1_b_q;          arith = 1'b0; end
            OP_SUB, OP_CMP: begin add_y = ~e1_b_q; add_cin = 1'b1; end
            OP_RSB:         begin add_x = e1_b_q; add_y = ~e1_a_q; add_cin = 1'b1; end
            OP_ADD, OP_CMN: add_cin = 1'b0;
            OP_ADC:         add_cin = carry_sel;
            OP_SBC:         begin add_y = ~e1_b_q; add_cin = carry_sel; end
            OP_RSC:         begin add_x = e1_b_q; add_y = ~e1_a_q; add_cin = carry_sel; end
            default:        arith = 1'b1;
        endcase

        sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};

        if (arith) begin
            alu_d = sum[WIDTH-1:0];
            c_res = sum[WIDTH];
            v_res = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (sum[WIDTH-1] != add_x[WIDTH-1]);
        end else begin
            c_res = e1_shc_q;
            v_res = flags_q[0];
        end

        is_test_d   = (e1_op_q == OP_TST) || (e1_op_q == OP_TEQ) ||
                      (e1_op_q == OP_CMP) || (e1_op_q == OP_CMN);
        set_flags_d = e1_s_q || is_test_d;
        flags_d     = {alu_d[WIDTH-1], (alu_d == '0), c_res, v_res};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e1_valid_q <= 1'b0;
            e1_op_q    <= OP_AND;
            e1_s_q     <= 1'b0;
            e1_a_q     <= '0;
            e1_b_q     <= '0;
            e1_shc_q   <= 1'b0;
            e1_tag_q   <= '0;
`ifndef ALU_CARRY_FWD_EN
            e1_cin_q   <= 1'b0;
`endif
            e2_valid_q <= 1'b0;
            alu_q      <= '0;
            rd_we_q    <= 1'b0;
            flags_we_q <= 1'b0;
            tag_q      <= '0;
            flags_q    <= 4'b0000;
        end else begin
            if (e1_adv) begin
                e1_valid_q <= in_valid;
                if (in_valid) begin
                    e1_op_q  <= op_e'(opcode_in);
                    e1_s_q   <= s_in;
                    e1_a_q   <= a_in;
                    e1_b_q   <= b_in;
                    e1_shc_q <= shift_c_in;
                    e1_tag_q <= tag_in;
`ifndef ALU_CARRY_FWD_EN
                    e1_cin_q <= carry_in;
`endif
                end
            end
            if (e2_adv) begin
                e2_valid_q <= e1_valid_q;
                if (e1_valid_q) begin
                    alu_q      <= alu_d;
                    rd_we_q    <= !is_test_d;
                    flags_we_q <= set_flags_d;
                    tag_q      <= e1_tag_q;
                    if (set_flags_d) begin
                        flags_q <= flags_d;
                    end
                end
            end
        end
    end

    assign out_valid = e2_valid_q;
    assign alu_out   = alu_q;
    assign rd_we     = rd_we_q;
    assign flags_we  = flags_we_q;
    assign tag_out   = tag_q;
    assign flags_out = flags_q;

endmodule
